// File: rtl/flappy_pkg.sv
// Shared constants, geometry and state encoding for the Flappy Bird game controller.
package flappy_pkg;

  localparam int unsigned SCR_TOP = 34;
  localparam int unsigned SCR_BOT = 515;
  localparam int unsigned BIRD_X  = 300;
  localparam int unsigned BIRD_SZ = 16;
  localparam int unsigned PIPE_W  = 60;
  localparam int unsigned GAP_H   = 120;
  localparam int unsigned GRAV    = 1;
  localparam int unsigned FLAP_V  = 8;
  localparam int unsigned VMAX    = 10;

  localparam int unsigned BIRD_Y0 = (SCR_TOP + SCR_BOT) / 2;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CALC_W  = 11;
  localparam int unsigned VEL_W   = 6;
  localparam int unsigned SCORE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_LOST = 2'b10
  } stateT;

endpackage

// File: rtl/flappy_game_ctrl_bcd.sv
// Four-digit BCD counter: synchronous clear, increment enable, wraps 9999 -> 0000.
module bcd_counter4
  import flappy_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Inc,
  output logic [SCORE_W-1:0] Count
);

  logic [SCORE_W-1:0] countNext;
  logic               carry;

  // Ripple the +1 through the digits; a 9 rolls to 0 and carries on.
  always_comb begin
    countNext = Count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (Count[i*4 +: 4] == 4'd9) begin
          countNext[i*4 +: 4] = 4'd0;
        end else begin
          countNext[i*4 +: 4] = Count[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      Count <= '0;
    end else if (Inc) begin
      Count <= countNext;
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird sequencer: IDLE/PLAY/LOST, bird physics, pipe collision and BCD score.
// Optional HIGH_SCORE_EN adds a HighScore output holding the best finished game.
module flappy_game_ctrl
  import flappy_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               FrameTick,
  input  logic               Start,
  input  logic               Flap,
  input  logic               Ack,
  input  logic [COORD_W-1:0] PipeX,
  input  logic [COORD_W-1:0] PipeY,
  output logic [COORD_W-1:0] BirdY,
  output logic [1:0]         State,
  output logic               PipeRun,
  output logic               Lost,
  output logic [SCORE_W-1:0] Score
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] HighScore
`endif
);

  stateT                    stateQ;
  logic signed [VEL_W-1:0]  vel;
  logic signed [VEL_W-1:0]  velInc;
  logic signed [VEL_W-1:0]  velNext;
  logic signed [CALC_W:0]   birdSum;
  logic [COORD_W-1:0]       birdYNext;
  logic [CALC_W-1:0]        birdBot;
  logic [CALC_W-1:0]        pipeRight;
  logic                     xOverlap;
  logic                     outOfGap;
  logic                     collide;
  logic                     scoreHit;
  logic                     flapQ;
  logic                     flapPend;
  logic                     flapRise;
  logic                     passed;

  assign State = stateQ;

  // Physics, collision and scoring decisions from the current registered state.
  always_comb begin
    flapRise = Flap & ~flapQ;
    velInc   = vel + $signed(VEL_W'(GRAV));
    if (flapPend) begin
      velNext = -VEL_W'(FLAP_V);
    end else if (velInc > $signed(VEL_W'(VMAX))) begin
      velNext = $signed(VEL_W'(VMAX));
    end else begin
      velNext = velInc;
    end
    birdSum   = $signed({2'b00, BirdY}) + $signed({{(CALC_W + 1 - VEL_W){velNext[VEL_W-1]}}, velNext});
    birdYNext = (birdSum < $signed((CALC_W + 1)'(SCR_TOP))) ? COORD_W'(SCR_TOP) : birdSum[COORD_W-1:0];

    birdBot   = CALC_W'(BirdY) + CALC_W'(BIRD_SZ);
    pipeRight = CALC_W'(PipeX) + CALC_W'(PIPE_W);
    xOverlap  = (CALC_W'(BIRD_X + BIRD_SZ) > CALC_W'(PipeX)) && (CALC_W'(BIRD_X) < pipeRight);
    outOfGap  = (CALC_W'(BirdY) < CALC_W'(PipeY)) ||
                (birdBot > (CALC_W'(PipeY) + CALC_W'(GAP_H)));
    collide   = (birdBot >= CALC_W'(SCR_BOT)) || (xOverlap && outOfGap);
    scoreHit  = (pipeRight < CALC_W'(BIRD_X)) && !passed;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ   <= ST_IDLE;
      BirdY    <= COORD_W'(BIRD_Y0);
      vel      <= '0;
      PipeRun  <= 1'b0;
      Lost     <= 1'b0;
      flapQ    <= 1'b0;
      flapPend <= 1'b0;
      passed   <= 1'b0;
    end else begin
      flapQ <= Flap;
      // A new edge wins over a same-cycle tick so it counts toward the next frame.
      if (flapRise) begin
        flapPend <= 1'b1;
      end else if (FrameTick) begin
        flapPend <= 1'b0;
      end

      case (stateQ)
        ST_IDLE: begin
          BirdY <= COORD_W'(BIRD_Y0);
          vel   <= '0;
          if (Start) begin
            stateQ  <= ST_PLAY;
            PipeRun <= 1'b1;
            passed  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (FrameTick) begin
            vel   <= velNext;
            BirdY <= birdYNext;
          end
          // Stays set while the pipe is left of the bird; re-arms when a new pipe wraps in.
          passed <= (pipeRight < CALC_W'(BIRD_X));
          if (collide) begin
            stateQ  <= ST_LOST;
            PipeRun <= 1'b0;
            Lost    <= 1'b1;
          end
        end
        ST_LOST: begin
          if (Ack) begin
            stateQ <= ST_IDLE;
            Lost   <= 1'b0;
            BirdY  <= COORD_W'(BIRD_Y0);
            vel    <= '0;
          end
        end
        default: begin
          stateQ  <= ST_IDLE;
          PipeRun <= 1'b0;
          Lost    <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter4 scoreCnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear ((stateQ == ST_IDLE) && Start),
    .Inc   ((stateQ == ST_PLAY) && scoreHit),
    .Count (Score)
  );

`ifdef HIGH_SCORE_EN
  // Valid BCD orders the same as binary, so a plain compare is a digit-wise compare.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HighScore <= '0;
    end else if ((stateQ == ST_LOST) && (Score > HighScore)) begin
      HighScore <= Score;
    end
  end
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Randomized bench for flappy_game_ctrl against a frame-level behavioural model.
module tb_flappy_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        FrameTick = 1'b0;
  logic        Start = 1'b0;
  logic        Flap = 1'b0;
  logic        Ack = 1'b0;
  logic [9:0]  PipeX = 10'd600;
  logic [9:0]  PipeY = 10'd250;
  logic [9:0]  BirdY;
  logic [1:0]  State;
  logic        PipeRun;
  logic        Lost;
  logic [15:0] Score;
`ifdef HIGH_SCORE_EN
  logic [15:0] HighScore;
`endif

  int total = 0;
  int bad = 0;

  // Model state: game phase (0 idle, 1 play, 2 lost), position, velocity, decimal score.
  int mState, mY, mVel, mScore, mHigh;
  bit mPassed, mPend, mFlapPrev;
  int curX = 600;
  int curY = 250;

  always #5 Clk = ~Clk;

  flappy_game_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .FrameTick (FrameTick),
    .Start     (Start),
    .Flap      (Flap),
    .Ack       (Ack),
    .PipeX     (PipeX),
    .PipeY     (PipeY),
    .BirdY     (BirdY),
    .State     (State),
    .PipeRun   (PipeRun),
    .Lost      (Lost),
    .Score     (Score)
`ifdef HIGH_SCORE_EN
    ,
    .HighScore (HighScore)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] toBcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic modelReset();
    mState = 0; mY = 274; mVel = 0; mScore = 0; mHigh = 0;
    mPassed = 0; mPend = 0; mFlapPrev = 0;
  endtask

  // Advance the model by one clock using the inputs being applied this cycle.
  task automatic modelStep(input bit tick, input bit start, input bit flap, input bit ack,
                           input int px, input int py);
    int bot, right, ny, nv;
    bit rise, hit, col, overlap;
    rise    = flap && !mFlapPrev;
    bot     = mY + 16;
    right   = px + 60;
    overlap = (316 > px) && (300 < right);
    col     = (bot >= 515) || (overlap && (mY < py || bot > py + 120));
    hit     = (right < 300) && !mPassed;
    case (mState)
      0: begin
        mY = 274; mVel = 0;
        if (start) begin mState = 1; mScore = 0; mPassed = 0; end
      end
      1: begin
        if (tick) begin
          nv = mPend ? -8 : ((mVel + 1 > 10) ? 10 : mVel + 1);
          ny = mY + nv;
          mY = (ny < 34) ? 34 : ny;
          mVel = nv;
        end
        if (hit) mScore = (mScore + 1) % 10000;
        mPassed = (right < 300);
        if (col) mState = 2;
      end
      default: begin
        if (mScore > mHigh) mHigh = mScore;
        if (ack) begin mState = 0; mY = 274; mVel = 0; end
      end
    endcase
    mPend = rise ? 1'b1 : (tick ? 1'b0 : mPend);
    mFlapPrev = flap;
  endtask

  task automatic step(input bit rst, input bit tick, input bit start, input bit flap,
                      input bit ack, input int px, input int py);
    Reset = rst; FrameTick = tick; Start = start; Flap = flap; Ack = ack;
    PipeX = 10'(px); PipeY = 10'(py);
    if (rst) modelReset();
    else modelStep(tick, start, flap, ack, px, py);
    @(posedge Clk);
    #1;
    checkVal("state", 32'(State), 32'(mState));
    checkVal("birdY", 32'(BirdY), 32'(mY));
    checkVal("pipeRun", 32'(PipeRun), 32'(mState == 1));
    checkVal("lost", 32'(Lost), 32'(mState == 2));
    checkVal("score", 32'(Score), 32'(toBcd(mScore)));
`ifdef HIGH_SCORE_EN
    checkVal("highScore", 32'(HighScore), 32'(toBcd(mHigh)));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, curX, curY);
  endtask

  initial begin
    modelReset();
    step(1, 0, 0, 0, 0, curX, curY);
    step(1, 0, 0, 0, 0, curX, curY);
    checkVal("rst_state", 32'(State), 32'd0);
    checkVal("rst_y", 32'(BirdY), 32'd274);

    step(0, 0, 1, 0, 0, curX, curY);
    checkVal("start_state", 32'(State), 32'd1);
    checkVal("start_run", 32'(PipeRun), 32'd1);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, curX, curY);
      idle(1);
    end
    checkVal("fall5_y", 32'(BirdY), 32'd289);

    step(0, 0, 0, 1, 0, curX, curY);
    step(0, 0, 0, 0, 0, curX, curY);
    step(0, 0, 0, 1, 0, curX, curY);
    step(0, 0, 0, 0, 0, curX, curY);
    step(0, 1, 0, 0, 0, curX, curY);
    checkVal("flap_y", 32'(BirdY), 32'd281);

    curX = 200; curY = 200;
    idle(4);
    checkVal("pass1", 32'(Score), 32'h0001);
    curX = 600; idle(1);
    curX = 200; idle(2);
    checkVal("pass2", 32'(Score), 32'h0002);

    curX = 290; curY = 300;
    idle(1);
    checkVal("hit_state", 32'(State), 32'd2);
    checkVal("hit_lost", 32'(Lost), 32'd1);
    step(0, 1, 0, 0, 0, curX, curY);
    checkVal("frozen_y", 32'(BirdY), 32'd281);
    step(0, 0, 1, 0, 0, curX, curY);
    checkVal("lost_start", 32'(State), 32'd2);
    step(0, 0, 0, 0, 1, curX, curY);
    checkVal("ack_state", 32'(State), 32'd0);
    checkVal("ack_y", 32'(BirdY), 32'd274);

    curX = 600;
    step(0, 0, 1, 0, 1, curX, curY);
    checkVal("start_wins", 32'(State), 32'd1);
    for (int i = 0; i < 9999; i++) begin
      step(0, 0, 0, 0, 0, 200, curY);
      step(0, 0, 0, 0, 0, 600, curY);
    end
    checkVal("score9999", 32'(Score), 32'h9999);
    step(0, 0, 0, 0, 0, 200, curY);
    checkVal("wrap", 32'(Score), 32'h0000);

    step(1, 0, 0, 0, 0, 600, curY);
    checkVal("midrst_state", 32'(State), 32'd0);
    checkVal("midrst_run", 32'(PipeRun), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) curX = 200;
      else if (sel == 1) curX = 600;
      else if (sel == 2) curX = int'($urandom_range(0, 1000));
      if ($urandom_range(0, 15) == 0) curY = int'($urandom_range(40, 400));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), curX, curY);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
